layer2_output_parity_buffer: RTL and testbench

Ping-pong-free storage stage between the layer-2 convolution engine and the layer-3 2x2 max-pooling stage. It captures layer-2 result pixels, each 8 channels x 16 bit, into four banks selected by row/column parity. When the full feature map is present it pulses `pixel_store_done`. It then serves 1-cycle-latency reads that return one complete 2x2 pooling window (even/even, even/odd, odd/even, odd/odd) per address.

---
 rtl/layer2_output_parity_buffer.sv | 94 +++++++++
 tb/tb_layer2_output_parity_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/layer2_output_parity_buffer.sv
// layer2_output_parity_buffer: parity-banked layer-2 pixel store serving 2x2 pooling windows.
// Ports: clk/rst (sync, active-high); save_enable/input_row/input_col/input_data write side;
// pixel_store_done one-cycle map-complete pulse; read_pixel_signal/read_row_addr/read_col_addr
// read side with 1-cycle latency into output_data_{even_even,even_odd,odd_even,odd_odd};
// layer3_calculation_done releases the map for refill; write_drop_err sticky drop flag.
module layer2_output_parity_buffer #(
    parameter int IN_DIM = 16,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_enable,
    input  logic [15:0]       input_row,
    input  logic [15:0]       input_col,
    input  logic [DATA_W-1:0] input_data,
    output logic              pixel_store_done,
    input  logic              read_pixel_signal,
    input  logic [15:0]       read_row_addr,
    input  logic [15:0]       read_col_addr,
    input  logic              layer3_calculation_done,
    output logic [DATA_W-1:0] output_data_even_even,
    output logic [DATA_W-1:0] output_data_even_odd,
    output logic [DATA_W-1:0] output_data_odd_even,
    output logic [DATA_W-1:0] output_data_odd_odd,
    output logic              write_drop_err
);
    localparam int POOL_DIM = IN_DIM / 2;
    localparam int DEPTH = POOL_DIM * POOL_DIM;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] DONE = 2'd1;
    localparam logic [1:0] READ = 2'd2;
    localparam logic [15:0] LAST = 16'(IN_DIM * IN_DIM - 1);

    logic [DATA_W-1:0] mem_ee [DEPTH];
    logic [DATA_W-1:0] mem_eo [DEPTH];
    logic [DATA_W-1:0] mem_oe [DEPTH];
    logic [DATA_W-1:0] mem_oo [DEPTH];
    logic [1:0]        state;
    logic [15:0]       wr_cnt;
    logic              wr_ok;
    logic              rd_ok;
    logic [1:0]        bank;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        wr_ok   = save_enable && state == FILL && input_row < 16'(IN_DIM) && input_col < 16'(IN_DIM);
        rd_ok   = read_row_addr < 16'(POOL_DIM) && read_col_addr < 16'(POOL_DIM);
        bank    = {input_row[0], input_col[0]};
        wr_addr = AW'(32'(input_row >> 1) * POOL_DIM + 32'(input_col >> 1));
        rd_addr = AW'(32'(read_row_addr) * POOL_DIM + 32'(read_col_addr));
    end

    assign pixel_store_done = state == DONE;

    // Banks carry no reset: every fill rewrites each location before it is read.
    always_ff @(posedge clk) begin
        if (wr_ok && bank == 2'b00) mem_ee[wr_addr] <= input_data;
        if (wr_ok && bank == 2'b01) mem_eo[wr_addr] <= input_data;
        if (wr_ok && bank == 2'b10) mem_oe[wr_addr] <= input_data;
        if (wr_ok && bank == 2'b11) mem_oo[wr_addr] <= input_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            wr_cnt         <= '0;
            write_drop_err <= 1'b0;
        end else begin
            if (save_enable && state != FILL) write_drop_err <= 1'b1;
            state  <= (state == FILL) ? ((wr_ok && wr_cnt == LAST) ? DONE : FILL) :
                      (state == DONE) ? READ :
                      (state == READ && !layer3_calculation_done) ? READ : FILL;
            wr_cnt <= (state == READ && layer3_calculation_done) ? '0 :
                      wr_ok ? wr_cnt + 16'd1 : wr_cnt;
        end
    end

    // Registered read of the old bank contents gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            output_data_even_even <= '0;
            output_data_even_odd  <= '0;
            output_data_odd_even  <= '0;
            output_data_odd_odd   <= '0;
        end else if (read_pixel_signal) begin
            output_data_even_even <= rd_ok ? mem_ee[rd_addr] : '0;
            output_data_even_odd  <= rd_ok ? mem_eo[rd_addr] : '0;
            output_data_odd_even  <= rd_ok ? mem_oe[rd_addr] : '0;
            output_data_odd_odd   <= rd_ok ? mem_oo[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_layer2_output_parity_buffer.sv
// tb_layer2_output_parity_buffer: directed self-checking bench for layer2_output_parity_buffer.
module tb_layer2_output_parity_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         save_enable = 1'b0;
    logic [15:0]  input_row = '0;
    logic [15:0]  input_col = '0;
    logic [127:0] input_data = '0;
    logic         pixel_store_done;
    logic         read_pixel_signal = 1'b0;
    logic [15:0]  read_row_addr = '0;
    logic [15:0]  read_col_addr = '0;
    logic         layer3_calculation_done = 1'b0;
    logic [127:0] output_data_even_even;
    logic [127:0] output_data_even_odd;
    logic [127:0] output_data_odd_even;
    logic [127:0] output_data_odd_odd;
    logic         write_drop_err;
    int           total = 0;
    int           fails = 0;

    layer2_output_parity_buffer #(.IN_DIM(16), .DATA_W(128)) dut (
        .clk(clk),
        .rst(rst),
        .save_enable(save_enable),
        .input_row(input_row),
        .input_col(input_col),
        .input_data(input_data),
        .pixel_store_done(pixel_store_done),
        .read_pixel_signal(read_pixel_signal),
        .read_row_addr(read_row_addr),
        .read_col_addr(read_col_addr),
        .layer3_calculation_done(layer3_calculation_done),
        .output_data_even_even(output_data_even_even),
        .output_data_even_odd(output_data_even_odd),
        .output_data_odd_even(output_data_odd_even),
        .output_data_odd_odd(output_data_odd_odd),
        .write_drop_err(write_drop_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int r, input int c, input logic [127:0] d);
        save_enable = 1'b1;
        input_row   = 16'(r);
        input_col   = 16'(c);
        input_data  = d;
        step();
        save_enable = 1'b0;
    endtask

    task automatic rd(input int r, input int c);
        read_pixel_signal = 1'b1;
        read_row_addr     = 16'(r);
        read_col_addr     = 16'(c);
        step();
        read_pixel_signal = 1'b0;
    endtask

    // Raster fill with pixel value row*16+col+off replicated over 8 channels.
    task automatic fill(input int off);
        for (int i = 0; i < 256; i++) begin
            wr(i / 16, i % 16, {8{16'(i + off)}});
            if (i == 254) chk("no_done_after_255", 128'(pixel_store_done), 128'd0);
        end
        chk("done_after_256", 128'(pixel_store_done), 128'd1);
        step();
        chk("done_one_cycle", 128'(pixel_store_done), 128'd0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_done", 128'(pixel_store_done), 128'd0);
        chk("rst_err", 128'(write_drop_err), 128'd0);
        chk("rst_ee", output_data_even_even, 128'd0);
        chk("rst_oo", output_data_odd_odd, 128'd0);
        for (int i = 0; i < 100; i++) wr(i / 16, i % 16, {8{16'hdead}});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midfill_rst_done", 128'(pixel_store_done), 128'd0);
        wr(16, 3, {8{16'hbeef}});
        chk("oor_write_no_err", 128'(write_drop_err), 128'd0);
        fill(0);
        rd(3, 5);
        chk("rd35_ee", output_data_even_even, {8{16'h006a}});
        chk("rd35_eo", output_data_even_odd, {8{16'h006b}});
        chk("rd35_oe", output_data_odd_even, {8{16'h007a}});
        chk("rd35_oo", output_data_odd_odd, {8{16'h007b}});
        read_row_addr = 16'd1;
        read_col_addr = 16'd1;
        for (int i = 0; i < 5; i++) step();
        chk("hold_ee", output_data_even_even, {8{16'h006a}});
        chk("hold_oo", output_data_odd_odd, {8{16'h007b}});
        rd(8, 0);
        chk("oor_rd_ee", output_data_even_even, 128'd0);
        chk("oor_rd_eo", output_data_even_odd, 128'd0);
        chk("oor_rd_oe", output_data_odd_even, 128'd0);
        chk("oor_rd_oo", output_data_odd_odd, 128'd0);
        chk("read_state_no_err", 128'(write_drop_err), 128'd0);
        wr(0, 0, {8{16'hffff}});
        chk("drop_err_set", 128'(write_drop_err), 128'd1);
        rd(0, 0);
        chk("drop_keeps_ee", output_data_even_even, {8{16'h0000}});
        chk("drop_keeps_eo", output_data_even_odd, {8{16'h0001}});
        chk("drop_keeps_oe", output_data_odd_even, {8{16'h0010}});
        layer3_calculation_done = 1'b1;
        step();
        layer3_calculation_done = 1'b0;
        chk("err_sticky", 128'(write_drop_err), 128'd1);
        fill(1);
        rd(3, 5);
        chk("refill_ee", output_data_even_even, {8{16'h006b}});
        chk("refill_eo", output_data_even_odd, {8{16'h006c}});
        chk("refill_oe", output_data_odd_even, {8{16'h007b}});
        chk("refill_oo", output_data_odd_odd, {8{16'h007c}});
        rd(0, 0);
        chk("refill_00_ee", output_data_even_even, {8{16'h0001}});
        chk("refill_00_oo", output_data_odd_odd, {8{16'h0012}});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("final_rst_err", 128'(write_drop_err), 128'd0);
        chk("final_rst_ee", output_data_even_even, 128'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
